// File: rtl/frame_reader.sv
// frame_reader: scans the framebuffer in 8-pixel blocks and streams returned beats downstream
module frame_reader #(
    parameter int H_BLOCKS        = 100,
    parameter int V_LINES         = 600,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  frame_base,
    input  logic         af_full,
    output logic         af_wr_en,
    output logic [30:0]  af_addr_din,
    output logic [2:0]   af_cmd_din,
    input  logic         rdf_valid,
    input  logic [127:0] rdf_dout,
    output logic         rdf_rd_en,
    input  logic         px_ready,
    output logic         px_wr_en,
    output logic [127:0] px_dout,
    output logic         busy,
    output logic         frame_done
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t      state_q, state_d;
    logic [5:0]  base_q, base_d;
    logic [6:0]  xblk_q, xblk_d;
    logic [9:0]  y_q, y_d;
    logic [3:0]  out_q, out_d;
    logic        tog_q, tog_d;
    logic        done_q, done_d;
    logic        last_x, last_cmd, pop, burst_end;
    logic        unused_base;
    assign unused_base = ^{frame_base[31:28], frame_base[21:0]};
    assign af_cmd_din  = 3'b001;
    assign af_addr_din = {6'b0, base_q, y_q, xblk_q, 2'b0};
    assign rdf_rd_en   = pop;
    assign px_wr_en    = pop;
    assign px_dout     = rdf_dout;
    assign busy        = state_q != IDLE;
    assign frame_done  = done_q;
    // Issue/return handshakes, scan counters, credit tracking and FSM next state
    always_comb begin
        last_x    = xblk_q == 7'(H_BLOCKS - 1);
        last_cmd  = last_x && y_q == 10'(V_LINES - 1);
        af_wr_en  = !rst && state_q == ISSUE && !af_full && out_q < 4'(MAX_OUTSTANDING);
        pop       = !rst && rdf_valid && px_ready && out_q != 4'd0;
        burst_end = pop && tog_q;
        out_d     = out_q + {3'b0, af_wr_en} - {3'b0, burst_end};
        tog_d     = tog_q ^ pop;
        state_d   = state_q;
        base_d    = base_q;
        xblk_d    = xblk_q;
        y_d       = y_q;
        if (state_q == IDLE && start) begin
            state_d = ISSUE;
            base_d  = frame_base[27:22];
            xblk_d  = 7'd0;
            y_d     = 10'd0;
        end
        if (af_wr_en) begin
            xblk_d  = last_x ? 7'd0 : xblk_q + 7'd1;
            y_d     = last_x ? y_q + 10'd1 : y_q;
            state_d = last_cmd ? DRAIN : state_q;
        end
        if (state_q == DRAIN && out_d == 4'd0)
            state_d = IDLE;
        done_d = state_q == DRAIN && state_d == IDLE;
    end
    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= 6'd0;
            xblk_q  <= 7'd0;
            y_q     <= 10'd0;
            out_q   <= 4'd0;
            tog_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            xblk_q  <= xblk_d;
            y_q     <= y_d;
            out_q   <= out_d;
            tog_q   <= tog_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: scoreboard bench for frame_reader on a 2x2-block frame with 2 credits
module tb_frame_reader;
    logic         clk = 0, rst = 1, start = 1, af_full = 0, rdf_valid = 0, px_ready = 1;
    logic [31:0]  frame_base = 0;
    logic [127:0] rdf_dout = 0;
    logic         af_wr_en, rdf_rd_en, px_wr_en, busy, frame_done;
    logic [30:0]  af_addr_din;
    logic [2:0]   af_cmd_din;
    logic [127:0] px_dout;

    frame_reader #(.H_BLOCKS(2), .V_LINES(2), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_base(frame_base), .af_full(af_full),
        .af_wr_en(af_wr_en), .af_addr_din(af_addr_din), .af_cmd_din(af_cmd_din),
        .rdf_valid(rdf_valid), .rdf_dout(rdf_dout), .rdf_rd_en(rdf_rd_en),
        .px_ready(px_ready), .px_wr_en(px_wr_en), .px_dout(px_dout),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {int rdy; logic [127:0] d;} beat_t;
    beat_t        mem[$];
    logic [30:0]  exp_addr[$];
    logic [127:0] exp_px[$];
    int ntests = 0, nfail = 0, cmd_cnt = 0, done_cnt = 0, ncyc = 0, last_pop = 0, cyc = 0, ret_budget = 1000;
    logic         fire_s = 0, pop_s = 0;
    logic [30:0]  addr_s = 0;

    function automatic logic [127:0] beat(input logic [30:0] a, input int k);
        return {1'b0, a, 32'(k), ~{1'b1, a}, 32'hC0DE_0000 + 32'(k)};
    endfunction

    function automatic logic [30:0] mk_addr(input logic [5:0] b, input int y, input int x);
        return {6'b0, b, 10'(y), 7'(x), 2'b00};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every command and forwarded beat against the expected queues
    always @(negedge clk) begin
        ncyc++;
        fire_s = af_wr_en;
        pop_s  = rdf_rd_en;
        addr_s = af_addr_din;
        if (af_wr_en === 1'b1) begin
            cmd_cnt++;
            if (exp_addr.size() == 0) begin
                ntests++; nfail++;
                $display("FAIL unexpected_cmd: got addr %h required no command", af_addr_din);
            end else begin
                chki("af_addr", int'(af_addr_din), int'(exp_addr.pop_front()));
                chki("af_cmd", int'(af_cmd_din), 1);
            end
        end
        if (rdf_rd_en === 1'b1 || px_wr_en === 1'b1) begin
            chki("pop_eq_push", int'(rdf_rd_en), int'(px_wr_en));
            if (px_wr_en) begin
                last_pop = ncyc;
                if (exp_px.size() == 0) begin
                    ntests++; nfail++;
                    $display("FAIL unexpected_beat: got %h required no beat", px_dout);
                end else
                    check("px_dout", px_dout, exp_px.pop_front());
            end
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            chki("done_timing", ncyc - last_pop, 1);
        end
    end

    // Memory model: two beats per accepted command, available 4 cycles later
    always @(posedge clk) begin
        #1;
        cyc++;
        if (pop_s && mem.size() > 0) begin
            void'(mem.pop_front());
            ret_budget--;
        end
        if (fire_s) begin
            mem.push_back('{cyc + 4, beat(addr_s, 0)});
            mem.push_back('{cyc + 4, beat(addr_s, 1)});
        end
        rdf_valid = mem.size() > 0 ? (mem[0].rdy <= cyc && ret_budget > 0) : 1'b0;
        rdf_dout  = mem.size() > 0 ? mem[0].d : '0;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_frame(input logic [5:0] b);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 2; x++) begin
                exp_addr.push_back(mk_addr(b, y, x));
                exp_px.push_back(beat(mk_addr(b, y, x), 0));
                exp_px.push_back(beat(mk_addr(b, y, x), 1));
            end
    endtask

    task automatic do_start(input logic [5:0] b);
        frame_base = {4'hF, b, 22'h2A_AAAA};
        start = 1;
        tick(1);
        start = 0;
    endtask

    task automatic wait_cmd();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (af_wr_en) begin
                tick(1);
                return;
            end
        end
        ntests++; nfail++;
        $display("FAIL wait_cmd: got no command in 50 cycles required one");
    endtask

    task automatic wait_done();
        int prev = done_cnt;
        int got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_done) begin
                got = 1;
                chki("busy_at_done", int'(busy), 0);
                break;
            end
        end
        chki("frame_done_seen", got, 1);
        tick(3);
        chki("done_once", done_cnt - prev, 1);
        chki("addr_q_empty", exp_addr.size(), 0);
        chki("px_q_empty", exp_px.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bad, sawv;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chki("rst_af_wr_en", int'(af_wr_en), 0);
        chki("rst_rdf_rd_en", int'(rdf_rd_en), 0);
        chki("rst_px_wr_en", int'(px_wr_en), 0);
        chki("rst_busy", int'(busy), 0);
        chki("rst_frame_done", int'(frame_done), 0);
        tick(1);
        rst = 0;
        start = 0;
        tick(5);
        @(negedge clk);
        chki("idle_busy", int'(busy), 0);
        chki("idle_cmds", cmd_cnt, 0);
        tick(1);

        cmd_cnt = 0;
        push_frame(6'h05);
        do_start(6'h05);
        wait_done();
        chki("small_cmds", cmd_cnt, 4);

        cmd_cnt = 0;
        push_frame(6'h2A);
        do_start(6'h2A);
        wait_cmd();
        af_full = 1;
        repeat (5) begin
            @(negedge clk);
            chki("af_full_stall", int'(af_wr_en), 0);
        end
        chki("busy_stall", int'(busy), 1);
        tick(1);
        af_full = 0;
        wait_done();
        chki("af_full_cmds", cmd_cnt, 4);

        cmd_cnt = 0;
        ret_budget = 0;
        push_frame(6'h11);
        do_start(6'h11);
        tick(12);
        chki("credit_cmds", cmd_cnt, 2);
        @(negedge clk);
        chki("credit_hold", int'(af_wr_en), 0);
        tick(1);
        ret_budget = 2;
        tick(12);
        chki("credit_more", cmd_cnt, 3);
        ret_budget = 1000;
        wait_done();

        cmd_cnt = 0;
        px_ready = 0;
        push_frame(6'h3F);
        do_start(6'h3F);
        bad = 0;
        sawv = 0;
        repeat (10) begin
            @(negedge clk);
            bad += int'(rdf_rd_en);
            sawv |= int'(rdf_valid);
        end
        chki("stall_no_pop", bad, 0);
        chki("stall_saw_valid", sawv, 1);
        chki("stall_cmds", cmd_cnt, 2);
        tick(1);
        px_ready = 1;
        wait_done();

        cmd_cnt = 0;
        push_frame(6'h0A);
        do_start(6'h0A);
        tick(3);
        do_start(6'h33);
        wait_done();
        chki("restart_cmds", cmd_cnt, 4);

        cmd_cnt = 0;
        exp_addr.push_back(mk_addr(6'h01, 0, 0));
        do_start(6'h01);
        wait_cmd();
        rst = 1;
        tick(1);
        rst = 0;
        mem.delete();
        exp_px.delete();
        rdf_valid = 0;
        @(negedge clk);
        chki("rst_mid_busy", int'(busy), 0);
        chki("rst_mid_cmds", cmd_cnt, 1);
        tick(10);
        @(negedge clk);
        chki("rst_after_busy", int'(busy), 0);
        chki("rst_after_cmds", cmd_cnt, 1);
        chki("rst_addr_q", exp_addr.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/frame_reader.md
# frame_reader

Read-side DRAM client that scans a framebuffer and streams its pixels to the display pipeline. It issues one read command per 8-pixel block through the shared address FIFO (af) and pops the returned 128-bit beats from the read-data FIFO (rdf). It forwards the beats in order to a downstream pixel FIFO. It uses the same framebuffer addressing scheme as the write-side drawing engines, so any pixel they write is read back from the identical location.

## Interface
Parameters:
- H_BLOCKS, 100: 8-pixel blocks per line, range 1..128.
- V_LINES, 600: lines per frame, range 1..1024.
- MAX_OUTSTANDING, 8: maximum read bursts issued but not fully returned, range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a frame read. Honoured only when the block is idle.
- frame_base  in  32  framebuffer base. Only bits [27:22] are used; they are latched on an accepted start.
- af_full  in  1  address FIFO full.
- af_wr_en  out  1  pushes a command into the address FIFO.
- af_addr_din  out  31  read address, {6'b0, base[27:22], y[9:0], xblk[6:0], 2'b0}.
- af_cmd_din  out  3  command code, constant 3'b001 (read).
- rdf_valid  in  1  the read-data FIFO head is valid.
- rdf_dout  in  128  read-data FIFO head, holding 4 pixels of 32 bits each.
- rdf_rd_en  out  1  pops the read-data FIFO.
- px_ready  in  1  the downstream pixel FIFO can accept a beat.
- px_wr_en  out  1  pushes px_dout downstream.
- px_dout  out  128  pixel beat, rdf_dout passed through unmodified.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle pulse when the last beat of a frame has been forwarded.

## Operation
- **States:**
  - IDLE → ISSUE on start. The start cycle latches base, sets xblk=0 and y=0.
  - ISSUE → DRAIN when the last command is accepted, i.e. at xblk=H_BLOCKS-1 and y=V_LINES-1.
  - DRAIN → IDLE when outstanding==0. frame_done is asserted in the cycle that enters IDLE.
- **Issue:** af_wr_en = (state==ISSUE) & ~af_full & (outstanding < MAX_OUTSTANDING). This is combinational. af_addr_din always reflects the current xblk and y.
- **Scan order:** on each accepted command, xblk increments. At H_BLOCKS-1, xblk wraps to 0 and y increments. Counters are 7-bit (xblk) and 10-bit (y) with no overflow beyond the parameter ranges.
- **Return path:**
  - rdf_rd_en = px_wr_en = rdf_valid & px_ready & (outstanding != 0).
  - A beat toggle bit flips on each pop.
  - The second beat of each burst (toggle 1→0) ends that burst.
- **outstanding counter:**
  - 4-bit.
  - +1 on af_wr_en.
  - −1 on the second-beat pop.
  - Both in the same cycle: unchanged.
- **Returned data:** pops with outstanding==0 are not performed; stray rdf data stays in the FIFO.
- **start:** start while busy is ignored, with no effect on counters or base.
- **Backpressure:** af_full or the credit limit stalls issue with all state held. px_ready low stalls only the return path; issue continues up to the credit limit.

## Timing
- **Reset values:** state IDLE, xblk=0, y=0, outstanding=0, toggle=0, base=0, busy=0, frame_done=0. Combinational outputs are low after reset: af_wr_en, rdf_rd_en, px_wr_en.
- **Reset mid-frame:** returns to IDLE in the next cycle with no further commands. The downstream owner flushes the FIFOs.
- **Issue latency:** the first af_wr_en can occur in the cycle after the accepted start.
- **Throughput:** one command per cycle. Return path carries one beat per cycle.
- **Pass-through:** px_dout has zero-cycle latency from rdf_dout.
- **frame_done:** asserted exactly 1 cycle after the final second-beat pop. busy falls in the same cycle frame_done rises.
- **Command count:** total commands per frame = H_BLOCKS·V_LINES. Total beats forwarded = 2·H_BLOCKS·V_LINES.

## Test plan
- **Reset:** hold rst for 3 cycles with start=1 → all outputs 0 and busy=0. After release with no start, no af_wr_en occurs.
- **Small frame:** H_BLOCKS=2, V_LINES=2, base[27:22]=6'h05, model returns 2 beats per command after 4 cycles.
  - Address sequence: xblk0/y0, xblk1/y0, xblk0/y1, xblk1/y1, i.e. {6'b0, 6'h05, y, xblk, 2'b00}.
  - 8 beats forwarded in order.
  - frame_done pulses once.
- **af backpressure:** af_full high for 5 cycles mid-line → af_wr_en=0 throughout, then the address sequence resumes with no skipped or duplicated addresses.
- **Credit limit:** MAX_OUTSTANDING=2 with no data returned → exactly 2 commands issued, then af_wr_en stays 0. Returning 2 beats → exactly 1 more command.
- **Downstream stall:** px_ready low for 10 cycles while rdf_valid=1 → rdf_rd_en=0 and no beats lost. Issue stops at the credit limit, and on release the beats arrive in address order.
- **start and reset during a frame:** start pulse mid-frame → command count unchanged and base not relatched. rst during ISSUE → IDLE next cycle, with af_wr_en and busy low thereafter.
